// File: rtl/frame_codec_pkg.sv
// Shared constants, state encodings and the byte-wide CRC16 step for frame_codec.
package frame_codec_pkg;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [31:0] DEFAULT_MAGIC = 32'hDABBAD00;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_HDR  = 3'd1,
        TX_PAY  = 3'd2,
        TX_CRC  = 3'd3,
        TX_GAP  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT   = 2'd0,
        RX_PAY    = 2'd1,
        RX_CRC_HI = 2'd2,
        RX_CRC_LO = 2'd3
    } rx_state_t;

    // One byte of CRC16, MSB first, no reflection.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_codec_crc16_byte.sv
// Combinational CRC16 step: folds one data byte into the running CRC.
module crc16_byte
    import frame_codec_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] next_crc
);

    assign next_crc = crc16_update(crc, data);

endmodule

// File: rtl/frame_codec.sv
// Framed byte codec: TX wraps a payload in MAGIC + CRC16 with an idle gap,
// RX hunts for MAGIC, collects the payload and publishes it only if the CRC matches.
module frame_codec
    import frame_codec_pkg::*;
#(
    parameter int unsigned PAYLOAD_BYTES = 14,
    parameter logic [31:0] MAGIC         = DEFAULT_MAGIC,
    parameter int unsigned GAP_CYCLES    = 2048
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [PAYLOAD_BYTES*8-1:0] tx_payload,
    input  logic                       tx_start,
    output logic                       tx_busy,
    output logic [7:0]                 tx_byte,
    output logic                       tx_byte_valid,
    input  logic                       tx_byte_ready,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_byte_valid,
    output logic [PAYLOAD_BYTES*8-1:0] rx_payload,
    output logic                       rx_frame_valid,
    output logic [15:0]                rx_frame_count,
    output logic [15:0]                rx_crc_err_count
);

    localparam int unsigned PW        = PAYLOAD_BYTES * 8;
    localparam logic [15:0] LAST_PAY  = 16'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] LAST_GAP  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] MAGIC_CRC = crc16_update(crc16_update(crc16_update(crc16_update(
                                            CRC16_INIT, MAGIC[31:24]), MAGIC[23:16]), MAGIC[15:8]), MAGIC[7:0]);

    // ---------------- TX ----------------
    tx_state_t     tx_state, tx_state_next;
    logic [15:0]   tx_cnt;
    logic [PW-1:0] tx_shift;
    logic [15:0]   tx_crc, tx_crc_next;
    logic          tx_xfer;

    assign tx_xfer = tx_byte_valid && tx_byte_ready;
    assign tx_busy = (tx_state != TX_IDLE);

    crc16_byte u_tx_crc (.crc(tx_crc), .data(tx_byte), .next_crc(tx_crc_next));

    // TX state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) tx_state <= TX_IDLE;
        else       tx_state <= tx_state_next;
    end

    // TX next state: byte phases advance on transfers, the gap on clocks
    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_start)                        tx_state_next = TX_HDR;
            TX_HDR:  if (tx_xfer && tx_cnt == 16'd3)      tx_state_next = TX_PAY;
            TX_PAY:  if (tx_xfer && tx_cnt == LAST_PAY)   tx_state_next = TX_CRC;
            TX_CRC:  if (tx_xfer && tx_cnt == 16'd1)      tx_state_next = TX_GAP;
            TX_GAP:  if (tx_cnt == LAST_GAP)              tx_state_next = TX_IDLE;
            default:                                      tx_state_next = TX_IDLE;
        endcase
    end

    // TX datapath: latch payload, load the next byte on each transfer, fold sent bytes into the CRC
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            tx_cnt        <= '0;
            tx_shift      <= '0;
            tx_crc        <= '0;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: if (tx_start) begin
                    tx_shift      <= tx_payload;
                    tx_crc        <= CRC16_INIT;
                    tx_byte       <= MAGIC[31:24];
                    tx_byte_valid <= 1'b1;
                    tx_cnt        <= '0;
                end
                TX_HDR: if (tx_xfer) begin
                    tx_crc <= tx_crc_next;
                    if (tx_cnt == 16'd3) begin
                        tx_cnt   <= '0;
                        tx_byte  <= tx_shift[7:0];
                        tx_shift <= tx_shift >> 8;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                        case (tx_cnt[1:0])
                            2'd0:    tx_byte <= MAGIC[23:16];
                            2'd1:    tx_byte <= MAGIC[15:8];
                            default: tx_byte <= MAGIC[7:0];
                        endcase
                    end
                end
                TX_PAY: if (tx_xfer) begin
                    tx_crc <= tx_crc_next;
                    if (tx_cnt == LAST_PAY) begin
                        tx_cnt  <= '0;
                        tx_byte <= tx_crc_next[15:8];
                    end else begin
                        tx_cnt   <= tx_cnt + 16'd1;
                        tx_byte  <= tx_shift[7:0];
                        tx_shift <= tx_shift >> 8;
                    end
                end
                TX_CRC: if (tx_xfer) begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt  <= 16'd1;
                        tx_byte <= tx_crc[7:0];
                    end else begin
                        tx_cnt        <= '0;
                        tx_byte       <= '0;
                        tx_byte_valid <= 1'b0;
                    end
                end
                TX_GAP: tx_cnt <= tx_cnt + 16'd1;
                default: ;
            endcase
        end
    end

    // ---------------- RX ----------------
    rx_state_t     rx_state, rx_state_next;
    logic [23:0]   rx_window;   // three previous bytes; with rx_byte forms the 4-byte window
    logic [15:0]   rx_crc, rx_crc_next;
    logic [7:0]    rx_crc_hi;
    logic [15:0]   rx_cnt;
    logic [PW-1:0] rx_shadow, rx_shadow_next;
    logic          rx_hit, rx_crc_ok;

    assign rx_hit    = ({rx_window, rx_byte} == MAGIC);
    assign rx_crc_ok = ({rx_crc_hi, rx_byte} == rx_crc);

    // New bytes enter at the top so byte 0 ends up in the lowest lane
    if (PAYLOAD_BYTES > 1) begin : g_shadow_multi
        assign rx_shadow_next = {rx_byte, rx_shadow[PW-1:8]};
    end else begin : g_shadow_single
        assign rx_shadow_next = rx_byte;
    end

    crc16_byte u_rx_crc (.crc(rx_crc), .data(rx_byte), .next_crc(rx_crc_next));

    // RX state register
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) rx_state <= RX_HUNT;
        else       rx_state <= rx_state_next;
    end

    // RX next state: only valid bytes move the parser
    always_comb begin
        rx_state_next = rx_state;
        if (rx_byte_valid) begin
            case (rx_state)
                RX_HUNT:   if (rx_hit)             rx_state_next = RX_PAY;
                RX_PAY:    if (rx_cnt == LAST_PAY) rx_state_next = RX_CRC_HI;
                RX_CRC_HI:                         rx_state_next = RX_CRC_LO;
                RX_CRC_LO:                         rx_state_next = RX_HUNT;
                default:                           rx_state_next = RX_HUNT;
            endcase
        end
    end

    // RX datapath: window, shadow payload, running CRC, and publish/count at frame end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rx_window        <= '0;
            rx_crc           <= '0;
            rx_crc_hi        <= '0;
            rx_cnt           <= '0;
            rx_shadow        <= '0;
            rx_payload       <= '0;
            rx_frame_valid   <= 1'b0;
            rx_frame_count   <= '0;
            rx_crc_err_count <= '0;
        end else begin
            rx_frame_valid <= 1'b0;
            if (rx_byte_valid) begin
                case (rx_state)
                    RX_HUNT: begin
                        if (rx_hit) begin
                            rx_window <= '0;
                            rx_crc    <= MAGIC_CRC;
                            rx_cnt    <= '0;
                        end else begin
                            rx_window <= {rx_window[15:0], rx_byte};
                        end
                    end
                    RX_PAY: begin
                        rx_shadow <= rx_shadow_next;
                        rx_crc    <= rx_crc_next;
                        rx_cnt    <= rx_cnt + 16'd1;
                    end
                    RX_CRC_HI: rx_crc_hi <= rx_byte;
                    RX_CRC_LO: begin
                        rx_window <= '0;
                        if (rx_crc_ok) begin
                            rx_payload     <= rx_shadow;
                            rx_frame_valid <= 1'b1;
                            rx_frame_count <= rx_frame_count + 16'd1;
                        end else if (rx_crc_err_count != 16'hFFFF) begin
                            rx_crc_err_count <= rx_crc_err_count + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
